// File: rtl/rr_arbiter8_if.sv
// rr_arbiter8_if -- request/grant bundle between requesters and rr_arbiter8.
//
// Signals:
//   req      [7:0]  per-requester request
//   done            current holder releases the resource
//   gnt      [7:0]  one-hot grant, all-zero when idle
//   gnt_idx  [2:0]  binary index of holder (decoder select)
//   gnt_vld         grant active (decoder enable)
//   timeout         one-cycle pulse on forced release
//
// Modports:
//   master  requester side (drives req/done)
//   slave   arbiter side (drives grant outputs)

interface rr_arbiter8_if;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       timeout;

    modport master (
        output req,
        output done,
        input  gnt,
        input  gnt_idx,
        input  gnt_vld,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output gnt,
        output gnt_idx,
        output gnt_vld,
        output timeout
    );
endinterface

// File: rtl/rr_arbiter8.sv
// rr_arbiter8 -- 8-way round-robin arbiter for a shared 3-to-8 decoded
// resource. One holder at a time; all outputs registered; at least one idle
// cycle between consecutive grants.
//
// Ports:
//   clk    input   single clock, rising edge
//   rst_n  input   asynchronous active-low reset
//   arb    slave   req/done in; gnt/gnt_idx/gnt_vld/timeout out
//
// Parameters:
//   TIMEOUT_CYCLES  maximum grant hold in cycles (2..255), used only when
//                   the hold timer is built.
//
// Build option:
//   ARB_TIMEOUT_EN  when defined, a grant held TIMEOUT_CYCLES cycles without
//                   release is forced off and timeout pulses for that
//                   release cycle. When undefined, grants are held until
//                   done or request drop, and timeout is tied low.
//
// State   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no holder; arbitrate req from ptr on the next edge
// GRANT   | holder gnt_idx owns the resource until done, req drop or
//         | (with the hold timer) expiry

module rr_arbiter8 #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_arbiter8_if.slave  arb
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] gnt_q, gnt_d;
    logic       vld_q, vld_d;
    logic       to_q, to_d;

    logic       pick_any;
    logic [2:0] pick_idx;
    logic       user_rel;
    logic       force_rel;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt_q, cnt_d;
`endif

    // Search ptr, ptr+1, ... ptr+7 (mod 8). Scanning from the far end down
    // leaves the nearest set request as the final assignment.
    always_comb begin
        pick_any = 1'b0;
        pick_idx = ptr_q;
        for (int i = 7; i >= 0; i--) begin
            if (arb.req[3'(ptr_q + 3'(i))]) begin
                pick_any = 1'b1;
                pick_idx = 3'(ptr_q + 3'(i));
            end
        end
    end

    always_comb begin
        user_rel  = arb.done || !arb.req[idx_q];
`ifdef ARB_TIMEOUT_EN
        force_rel = (cnt_q == HOLD_LAST);
`else
        force_rel = 1'b0;
`endif
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        gnt_d   = gnt_q;
        vld_d   = vld_q;
        to_d    = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = GRANT;
                    idx_d   = pick_idx;
                    gnt_d   = 8'b0000_0001 << pick_idx;
                    vld_d   = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = 8'd0;
`endif
                end
            end
            GRANT: begin
                if (user_rel || force_rel) begin
                    state_d = IDLE;
                    gnt_d   = 8'h00;
                    vld_d   = 1'b0;
                    ptr_d   = 3'(idx_q + 3'd1);
                    // A normal release in the same cycle wins: no pulse.
                    to_d    = force_rel && !user_rel;
                end
`ifdef ARB_TIMEOUT_EN
                else begin
                    cnt_d = 8'(cnt_q + 8'd1);
                end
`endif
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 8'h00;
                vld_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            idx_q   <= 3'd0;
            gnt_q   <= 8'h00;
            vld_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            vld_q   <= vld_d;
            to_q    <= to_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign arb.timeout = to_q;
`else
    // Pulse register is never set without the hold timer; kept so both
    // builds share one next-state block.
    assign arb.timeout = 1'b0;
`endif

    assign arb.gnt     = gnt_q;
    assign arb.gnt_idx = idx_q;
    assign arb.gnt_vld = vld_q;

endmodule

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 16, maximum grant hold in cycles (used only with ARB_TIMEOUT_EN; legal 2..255).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: req  input  8  per-requester request for the shared 3-to-8 decoded resource.
REQ-005 SHALL have port: done  input  1  current holder releases resource.
REQ-006 SHALL have port: gnt  output  8  one-hot grant; all-zero when no grant.
REQ-007 SHALL have port: gnt_idx  output  3  binary index of holder; drives decoder select.
REQ-008 SHALL have port: gnt_vld  output  1  grant active; drives decoder enable.
REQ-009 SHALL have port: timeout  output  1  one-cycle pulse on forced release.

Function
REQ-010 SHALL implement two states: IDLE, GRANT; all outputs registered.
REQ-011 SHALL maintain 3-bit round-robin pointer ptr; search order ptr, ptr+1, ... ptr+7 modulo 8.
REQ-012 IDLE: if req != 0 at edge N, SHALL move to GRANT with gnt_idx = first set bit in search order, gnt_vld=1, gnt = one-hot(gnt_idx) visible after edge N (1-cycle latency).
REQ-013 IDLE with req == 0 SHALL remain IDLE; done ignored in IDLE.
REQ-014 GRANT: gnt, gnt_idx SHALL hold constant regardless of other req changes.
REQ-015 GRANT: if done=1 or req[gnt_idx]=0 at an edge, SHALL return to IDLE, clear gnt and gnt_vld, set ptr = gnt_idx+1 modulo 8 (7 wraps to 0).
REQ-016 SHALL insert at least one IDLE cycle (gnt_vld=0) between consecutive grants.
REQ-017 gnt SHALL always equal one-hot(gnt_idx) when gnt_vld=1 and 8'h00 when gnt_vld=0; gnt_idx SHALL retain last value while idle.
REQ-018 done and new requests in same cycle: release first; new requests arbitrated from IDLE next edge with updated ptr.
REQ-019 No requester SHALL wait more than 7 other grants while continuously requesting.

Reset
REQ-020 rst_n=0 SHALL immediately force state IDLE, gnt=8'h00, gnt_idx=0, gnt_vld=0, timeout=0, ptr=0, hold counter=0.
REQ-021 Reset asserted mid-grant SHALL drop the grant without timeout pulse; first arbitration after release starts at requester 0.

Configuration
REQ-022 Macro ARB_TIMEOUT_EN defined: 8-bit hold counter clears on GRANT entry, increments each GRANT cycle; when TIMEOUT_CYCLES GRANT cycles elapse without release, SHALL force release as REQ-015 and pulse timeout=1 for the release cycle only.
REQ-023 done and timeout in same cycle: normal release, timeout stays 0.
REQ-024 Macro undefined: no counter, grant held indefinitely, timeout tied 0.

Verification
REQ-025 Reset, req=8'h00 for 5 cycles -> gnt=8'h00, gnt_vld=0, gnt_idx=0 throughout.
REQ-026 req=8'hFF constant, done pulsed each grant -> gnt_idx sequence 0,1,2,...,7,0 with one idle cycle between grants.
REQ-027 req=8'b1000_0001 after grant to 7 released -> next gnt_idx=0 (wrap); then idx 7 after 0 released.
REQ-028 Grant to 3, req[3] drops at edge N with no done -> gnt_vld=0 after edge N; req=8'h30 -> next grant idx 4.
REQ-029 ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, req=8'h04, done=0 -> gnt=8'h04 for 16 cycles, then release with timeout=1 for one cycle; re-grant to 2 after one idle cycle.
REQ-030 rst_n low mid-grant to idx 5 -> outputs zero asynchronously; after rst_n high with req=8'h21 -> grant idx 0.
